// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a shared-ALU, unified-memory RV32I
// multicycle datapath. Sequences one instruction over 3-5 cycles.
// Ports:
//   clk, reset (sync, active-low)        clock and reset
//   op, funct3, funct7b5                 fields of the instruction register
//   Zero, V, N, C                        ALU flags of the current ALU result
//   PCWrite, IRWrite, MemWrite, RegWrite register/memory write enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB  datapath mux selects
//   ImmSrc, ALUControl                   immediate format and ALU operation
//   Trap                                 high while halted on an illegal opcode
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       V,
    input  logic       N,
    input  logic       C,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       Trap
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
    localparam logic [3:0] S_AUIPC    = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [3:0] state_q, state_d;
    logic [3:0] funct_alu;
    logic       br_taken;
    logic [2:0] imm_src;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Immediate format from opcode, valid in every state.
    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:          imm_src = 3'b001;
            OP_BRANCH:         imm_src = 3'b010;
            OP_JAL:            imm_src = 3'b011;
            OP_LUI, OP_AUIPC:  imm_src = 3'b100;
            default:           imm_src = 3'b000;
        endcase
    end

    // ALU operation for R/I arithmetic; sub only for R-type (op[5]=1).
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_alu = ALU_SLL;
            3'b010:  funct_alu = ALU_SLT;
            3'b011:  funct_alu = ALU_SLTU;
            3'b100:  funct_alu = ALU_XOR;
            3'b101:  funct_alu = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_alu = ALU_OR;
            default: funct_alu = ALU_AND;
        endcase
    end

    // Branch condition from the flags of rs1 - rs2.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = ~Zero;
            3'b100:  br_taken = N ^ V;
            3'b101:  br_taken = ~(N ^ V);
            3'b110:  br_taken = ~C;
            3'b111:  br_taken = C;
            default: br_taken = 1'b0;
        endcase
    end

    // Next state and Moore outputs; enables and Trap are masked during reset.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        Trap       = 1'b0;
        ImmSrc     = imm_src;
        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01; RegWrite = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1; MemWrite = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10; ALUControl = funct_alu;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = funct_alu;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10; ALUControl = ALU_SUB; PCWrite = br_taken;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11; ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                Trap = 1'b1;
                state_d = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Trap     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// hand-derived output vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, V, N, C;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .V(V), .N(N), .C(C),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Trap(Trap)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Trap}
    typedef logic [19:0] vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic vec_t mk(logic pcw, logic adr, logic mw, logic irw, logic rw,
                                logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                logic [2:0] imm, logic [3:0] alu, logic trap);
        return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, trap};
    endfunction

    // Expected vectors per state, written out from the state table.
    function automatic vec_t e_fetch(logic [2:0] imm);  return mk(1,0,0,1,0,2'b10,2'b00,2'b10,imm,4'b0000,0); endfunction
    function automatic vec_t e_decode(logic [2:0] imm); return mk(0,0,0,0,0,2'b00,2'b01,2'b01,imm,4'b0000,0); endfunction
    function automatic vec_t e_memadr(logic [2:0] imm); return mk(0,0,0,0,0,2'b00,2'b10,2'b01,imm,4'b0000,0); endfunction
    function automatic vec_t e_aluwb(logic [2:0] imm);  return mk(0,0,0,0,1,2'b00,2'b00,2'b00,imm,4'b0000,0); endfunction

    vec_t dut_vec;
    assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Trap};

    // One clock of stimulus: apply inputs after the edge, queue the expectation.
    task automatic cyc(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [3:0] zvnc, input vec_t e, input string nm);
        @(posedge clk);
        #1;
        reset = rst; op = o; funct3 = f3; funct7b5 = f7;
        {Zero, V, N, C} = zvnc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: combinational outputs are stable by the falling edge.
    initial begin
        vec_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (dut_vec !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", nm, dut_vec, e);
                end
            end
        end
    end

    localparam logic [6:0] LW  = 7'b0000011, SW  = 7'b0100011, RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011, BR  = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111, AUI = 7'b0010111, ILL = 7'b1111111;

    task automatic run_exec(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic [3:0] alu, input string nm);
        logic [1:0] b;
        b = (o == RT) ? 2'b00 : 2'b01;
        cyc(1, o, f3, f7, 4'b0, e_fetch(3'b000), {nm, " fetch"});
        cyc(1, o, f3, f7, 4'b0, e_decode(3'b000), {nm, " decode"});
        cyc(1, o, f3, f7, 4'b0, mk(0,0,0,0,0,2'b00,2'b10,b,3'b000,alu,0), {nm, " exec"});
        cyc(1, o, f3, f7, 4'b0, e_aluwb(3'b000), {nm, " aluwb"});
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic [3:0] zvnc,
                              input logic taken, input string nm);
        cyc(1, BR, f3, 0, zvnc, e_fetch(3'b010), {nm, " fetch"});
        cyc(1, BR, f3, 0, zvnc, e_decode(3'b010), {nm, " decode"});
        cyc(1, BR, f3, 0, zvnc, mk(taken,0,0,0,0,2'b00,2'b10,2'b00,3'b010,4'b0001,0), {nm, " branch"});
    endtask

    initial begin
        reset = 1'b0; op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
        Zero = 1'b0; V = 1'b0; N = 1'b0; C = 1'b0;

        // Reset held: FETCH selects visible, all enables masked.
        for (int i = 0; i < 3; i++)
            cyc(0, LW, 3'b010, 0, 4'b0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,4'b0000,0), "reset");

        // lw: 5 cycles.
        cyc(1, LW, 3'b010, 0, 4'b0, e_fetch(3'b000), "lw fetch");
        cyc(1, LW, 3'b010, 0, 4'b0, e_decode(3'b000), "lw decode");
        cyc(1, LW, 3'b010, 0, 4'b0, e_memadr(3'b000), "lw memadr");
        cyc(1, LW, 3'b010, 0, 4'b0, mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0), "lw memread");
        cyc(1, LW, 3'b010, 0, 4'b0, mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,4'b0000,0), "lw memwb");

        // sw: 4 cycles.
        cyc(1, SW, 3'b010, 0, 4'b0, e_fetch(3'b001), "sw fetch");
        cyc(1, SW, 3'b010, 0, 4'b0, e_decode(3'b001), "sw decode");
        cyc(1, SW, 3'b010, 0, 4'b0, e_memadr(3'b001), "sw memadr");
        cyc(1, SW, 3'b010, 0, 4'b0, mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0), "sw memwrite");

        // R and I arithmetic.
        run_exec(RT, 3'b000, 1, 4'b0001, "sub");
        run_exec(IT, 3'b000, 1, 4'b0000, "addi");
        run_exec(IT, 3'b101, 1, 4'b0111, "srai");
        run_exec(RT, 3'b101, 0, 4'b1000, "srl");
        run_exec(RT, 3'b010, 0, 4'b0101, "slt");
        run_exec(IT, 3'b011, 0, 4'b1001, "sltiu");
        run_exec(RT, 3'b110, 0, 4'b0011, "or");
        run_exec(IT, 3'b111, 0, 4'b0010, "andi");

        // Branches; flags packed as {Zero,V,N,C}.
        run_branch(3'b000, 4'b1000, 1, "beq z1");
        run_branch(3'b001, 4'b1000, 0, "bne z1");
        run_branch(3'b110, 4'b0000, 1, "bltu c0");
        run_branch(3'b101, 4'b0110, 1, "bge n1v1");
        run_branch(3'b100, 4'b0010, 1, "blt n1v0");
        run_branch(3'b010, 4'b1111, 0, "f3 010");

        // jal, lui, auipc.
        cyc(1, JAL, 3'b000, 0, 4'b0, e_fetch(3'b011), "jal fetch");
        cyc(1, JAL, 3'b000, 0, 4'b0, e_decode(3'b011), "jal decode");
        cyc(1, JAL, 3'b000, 0, 4'b0, mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b011,4'b0000,0), "jal jal");
        cyc(1, JAL, 3'b000, 0, 4'b0, e_aluwb(3'b011), "jal aluwb");
        cyc(1, LUI, 3'b000, 0, 4'b0, e_fetch(3'b100), "lui fetch");
        cyc(1, LUI, 3'b000, 0, 4'b0, e_decode(3'b100), "lui decode");
        cyc(1, LUI, 3'b000, 0, 4'b0, mk(0,0,0,0,0,2'b00,2'b11,2'b01,3'b100,4'b0000,0), "lui exec");
        cyc(1, LUI, 3'b000, 0, 4'b0, e_aluwb(3'b100), "lui aluwb");
        cyc(1, AUI, 3'b000, 0, 4'b0, e_fetch(3'b100), "auipc fetch");
        cyc(1, AUI, 3'b000, 0, 4'b0, e_decode(3'b100), "auipc decode");
        cyc(1, AUI, 3'b000, 0, 4'b0, mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b100,4'b0000,0), "auipc exec");
        cyc(1, AUI, 3'b000, 0, 4'b0, e_aluwb(3'b100), "auipc aluwb");

        // sw aborted by reset in its MEMWRITE cycle: MemWrite masked.
        cyc(1, SW, 3'b010, 0, 4'b0, e_fetch(3'b001), "abort fetch");
        cyc(1, SW, 3'b010, 0, 4'b0, e_decode(3'b001), "abort decode");
        cyc(1, SW, 3'b010, 0, 4'b0, e_memadr(3'b001), "abort memadr");
        cyc(0, SW, 3'b010, 0, 4'b0, mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0), "abort memwrite");
        cyc(1, SW, 3'b010, 0, 4'b0, e_fetch(3'b001), "abort refetch");
        cyc(1, SW, 3'b010, 0, 4'b0, e_decode(3'b001), "abort decode2");
        cyc(1, SW, 3'b010, 0, 4'b0, e_memadr(3'b001), "abort memadr2");
        cyc(1, SW, 3'b010, 0, 4'b0, mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b001,4'b0000,0), "abort memwrite2");

        // Illegal opcode: sticky trap, then reset recovers.
        cyc(1, ILL, 3'b000, 0, 4'b0, e_fetch(3'b000), "ill fetch");
        cyc(1, ILL, 3'b000, 0, 4'b0, e_decode(3'b000), "ill decode");
        for (int i = 0; i < 10; i++)
            cyc(1, ILL, 3'b000, 0, 4'b1111, mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,1), "trap");
        cyc(0, ILL, 3'b000, 0, 4'b0, mk(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'b0000,0), "trap reset");
        cyc(1, LW, 3'b010, 0, 4'b0, e_fetch(3'b000), "resume fetch");
        cyc(1, LW, 3'b010, 0, 4'b0, e_decode(3'b000), "resume decode");
        cyc(1, LW, 3'b010, 0, 4'b0, e_memadr(3'b000), "resume memadr");

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle RV32I control unit: a Moore state machine that sequences a shared-ALU, unified-memory multicycle datapath, one instruction at a time, over 3–5 clock cycles. It sits beside the multicycle datapath and drives the PC, instruction-register, memory and register-file enables and every mux select. It decodes ALUControl with the same encoding as the single-cycle ALU. It latches a sticky trap on unsupported opcodes.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; sampled on rising clk
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero, V, N, C  in  1 each  ALU flags of current-cycle ALU result
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 (A), 11=32'b0
- ALUSrcB  out  2  00=rs2 (WriteData), 01=ImmExt, 10=4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 sra, 1000 srl, 1001 sltu
- Trap  out  1  high while in TRAP

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, AUIPC, TRAP.
- Any output not listed for a state is 0. ImmSrc is decoded from op in every state; unknown op gives 000.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut <= OldPC+imm). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other op → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct-decoded ALUControl. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct-decoded ALUControl. Next is ALUWB.
- Funct decode:
  - funct3 000: sub only if funct7b5 & op[5], else add
  - 001 sll; 010 slt; 011 sltu; 100 xor; 110 or; 111 and
  - 101: sra if funct7b5, else srl (applies to both R and I forms)
- ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=taken, combinational from flags. Next is FETCH.
  - funct3 000 → Zero; 001 → !Zero; 100 → N^V; 101 → !(N^V); 110 → !C; 111 → C
  - funct3 010 or 011 → not taken
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next is ALUWB, which writes OldPC+4 to rd.
- LUI: ALUSrcA=11, ALUSrcB=01, add. Next is ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add. Next is ALUWB.
- TRAP: Trap=1, all enables 0. Remains in TRAP until reset.

## Timing
- Reset: while reset==0 at a rising edge, state <= FETCH.
- While reset==0, PCWrite, IRWrite, MemWrite, RegWrite and Trap are forced 0, overriding state-derived values.
- Reset asserted mid-instruction aborts it. No partial write occurs after the reset edge.
- The first FETCH enables assert in the cycle after reset samples 1.
- Outputs are combinational from state (plus op/funct3/funct7b5, and flags in BRANCH). There are no registered outputs and no output latency beyond state.
- Cycles per instruction:
  - lw: 5
  - sw, R-type, I-type ALU, jal, lui, auipc: 4
  - branch: 3, taken or not
- TRAP is sticky; Trap=1 from the cycle after DECODE until reset.

## Test plan
- Reset: hold reset=0 for 3 cycles with op=0000011 → all enables 0, Trap=0. Release → FETCH asserts PCWrite=1, IRWrite=1, ALUSrcB=10.
- lw (op=0000011, funct3=010): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB → AdrSrc=1 in MEMREAD, RegWrite=1 only in cycle 5, ResultSrc=01 there.
- sw, then sub (op=0110011, funct3=000, funct7b5=1): MemWrite=1 only in cycle 4 of sw. sub's EXECR has ALUControl=0001. addi with funct7b5=1 → ALUControl=0000. srai (funct3=101, funct7b5=1) → 0111.
- Branches: beq with Zero=1 → PCWrite=1 in cycle 3; bne with Zero=1 → PCWrite=0; bltu with C=0 → taken; bge with N=1, V=1 → taken.
- jal, lui, auipc: jal asserts PCWrite in cycles 1 and 3 and RegWrite in cycle 4. lui EXEC selects ALUSrcA=11 with ImmSrc=100.
- Illegal op=1111111 → TRAP; Trap=1 and no enables for 10 cycles; reset=0 then 1 → FETCH resumes.
